serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder: the stage that consumes the one-bit full adder's sum and cout outputs.
- Each clock, one bit from each operand and a registered carry pass through the full-adder cell. The cell's cout is fed back as the next cycle's carry.
- Adds two WIDTH-bit operands plus carry-in over WIDTH cycles.
- Presents the result with a start/busy/done handshake to the surrounding datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1 to 32.

Ports:
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when idle
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; result registers updated this cycle
- sum  output  WIDTH  result of the last completed addition
- cout  output  1  carry-out of the last completed addition

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal shift registers, carry and bit counter all cleared.
- States: IDLE and RUN.
- IDLE, start=1 at a rising edge:
  - load shift_a<=a, shift_b<=b, carry<=cin, count<=0, shift_s<=0
  - go to RUN; busy=1 from that edge
- RUN, each rising edge:
  - full-adder cell computes s = shift_a[0]^shift_b[0]^carry
  - co = majority(shift_a[0], shift_b[0], carry)
  - shift_a and shift_b shift right by one, with 0 into the MSB
  - shift_s shifts right with s into bit WIDTH-1
  - carry<=co, count<=count+1
- RUN, on the edge where count==WIDTH-1:
  - sum<={s, shift_s[WIDTH-1:1]}, cout<=co
  - done<=1, busy<=0, state<=IDLE
- Latency: start sampled at edge N; done=1 and sum/cout valid after edge N+WIDTH. This is exactly WIDTH edges of RUN.
- done is high for exactly one cycle. It deasserts at the next edge unless another completion occurs.
- Back-to-back: start=1 during the done cycle is accepted, because the FSM is already in IDLE. The next done follows WIDTH edges later, with no dead cycle.
- Start while busy: ignored. Operands and result are unaffected, with no queueing.
- sum/cout hold the previous result for the whole of RUN. They change only on the completion edge.
- a, b and cin may change freely after the accepting edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter width: enough to hold WIDTH-1, i.e. clog2(WIDTH), minimum 1 bit.
- WIDTH=1: RUN lasts one edge; done follows the accepting edge by one cycle.
- Reset mid-operation: immediate abort with all reset values. No done pulse. The previous sum/cout are cleared to 0.
- Reset deasserted with start=1: start is sampled at the first edge after release and is accepted.

Test Plan:
- Reset, then start with a=0x00, b=0x00, cin=0 -> busy high for 8 cycles; done pulse 8 edges after start; sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x3C, b=0x0F, cin=0 issued in the done cycle -> accepted back-to-back; sum=0x4B, cout=0 exactly 8 edges later.
- a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Assert start again with a=0x11 at RUN count 3 -> ignored, result unchanged. sum stays at the prior value until the completion edge.
- Start a=0x80, b=0x80, cin=1; assert rst asynchronously mid-edge at count 4 -> outputs 0 immediately, with no done pulse. A fresh run 0x80+0x80+1 -> sum=0x01, cout=1.
- WIDTH=4 exhaustive: all 512 (a, b, cin) combinations -> {cout,sum} equals a+b+cin; done exactly 4 edges after each start.
- WIDTH=1: all 8 input combinations -> matches the full-adder truth table, e.g. 1+1+1 -> sum=1, cout=1; done one edge after start.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake and data bundle between a serial_adder and the datapath driving it.
// Ports: start/a/b/cin flow into the adder; busy/done/sum/cout flow back out.
// master = requesting datapath side, slave = the adder itself.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one operand bit per clock through a full-adder cell.
// Latency: start accepted at edge N, done pulse and result registered at edge N+WIDTH.
// Backpressure: none; start is sampled only in IDLE and ignored while busy (no queueing).
// Ports: clk_i rising-edge clock, rst_i async active-high reset,
//        bus (slave): start/a/b/cin in, busy/done/sum/cout out.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  serial_adder_if.slave bus
);

  // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] shift_s_q, shift_s_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic [CW-1:0]    count_q, count_d;

  // Full-adder cell on the current LSBs and the registered carry.
  logic fa_s, fa_co;
  assign fa_s  = shift_a_q[0] ^ shift_b_q[0] ^ carry_q;
  assign fa_co = (shift_a_q[0] & shift_b_q[0]) |
                 (shift_a_q[0] & carry_q) |
                 (shift_b_q[0] & carry_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      shift_s_q <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      shift_s_q <= shift_s_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    shift_s_d = shift_s_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    done_d    = 1'b0;
    count_d   = count_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_a_d = bus.a;
          shift_b_d = bus.b;
          shift_s_d = '0;
          carry_d   = bus.cin;
          count_d   = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        shift_a_d = shift_a_q >> 1;
        shift_b_d = shift_b_q >> 1;
        // New sum bit enters at the MSB so the LSB-first result ends up aligned.
        shift_s_d = shift_s_q >> 1;
        shift_s_d[WIDTH-1] = fa_s;
        carry_d = fa_co;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          sum_d   = shift_s_d;
          cout_d  = fa_co;
          done_d  = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk_i(clk), .rst_i(rst), .bus(if8.slave));
  serial_adder #(.WIDTH(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(if4.slave));
  serial_adder #(.WIDTH(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));

  int n_chk = 0;
  int n_bad = 0;
  logic [63:0] prev [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input int w);
    return (w == 8) ? 0 : (w == 4) ? 1 : 2;
  endfunction

  task automatic drv(input int w, input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic c);
    case (w)
      8: begin if8.start = s; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = c; end
      4: begin if4.start = s; if4.a = a[3:0]; if4.b = b[3:0]; if4.cin = c; end
      default: begin if1.start = s; if1.a = a[0:0]; if1.b = b[0:0]; if1.cin = c; end
    endcase
  endtask

  function automatic logic [63:0] res(input int w);
    case (w)
      8: return 64'({if8.cout, if8.sum});
      4: return 64'({if4.cout, if4.sum});
      default: return 64'({if1.cout, if1.sum});
    endcase
  endfunction

  function automatic logic [63:0] busy(input int w);
    case (w)
      8: return 64'(if8.busy);
      4: return 64'(if4.busy);
      default: return 64'(if1.busy);
    endcase
  endfunction

  function automatic logic [63:0] done(input int w);
    case (w)
      8: return 64'(if8.done);
      4: return 64'(if4.done);
      default: return 64'(if1.done);
    endcase
  endfunction

  // Issue one addition and follow it to its done pulse. Called between edges;
  // returns #1 after the completion edge so a back-to-back start can be driven.
  // poke_at >= 0 re-asserts start (a=0x11) while the run is at that bit index.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input int poke_at);
    logic [63:0] exp;
    int lat;
    exp = (64'(a) + 64'(b) + 64'(c)) & ((64'd1 << (w + 1)) - 64'd1);
    drv(w, 1'b1, a, b, c);
    @(posedge clk); #1;
    chk("busy_on_accept", busy(w), 64'd1);
    chk("done_low_on_accept", done(w), 64'd0);
    drv(w, 1'b0, $urandom, $urandom, 1'($urandom));
    lat = 0;
    while (lat < 64) begin
      if (lat == poke_at)
        drv(w, 1'b1, 32'h11, $urandom, 1'($urandom));
      else if (poke_at >= 0 && lat == poke_at + 1)
        drv(w, 1'b0, $urandom, $urandom, 1'($urandom));
      @(posedge clk); #1;
      lat++;
      if (done(w) == 64'd1) break;
      chk("busy_in_run", busy(w), 64'd1);
      chk("sum_hold", res(w), prev[idx(w)]);
    end
    chk("latency", 64'(lat), 64'(w));
    chk("busy_at_done", busy(w), 64'd0);
    chk("result", res(w), exp);
    prev[idx(w)] = exp;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) prev[i] = 64'd0;
    drv(8, 1'b0, 0, 0, 1'b0);
    drv(4, 1'b0, 0, 0, 1'b0);
    drv(1, 1'b0, 0, 0, 1'b0);
    #1 rst = 1'b1;
    #20;
    foreach (prev[i]) begin
      int w;
      w = (i == 0) ? 8 : (i == 1) ? 4 : 1;
      chk("rst_busy", busy(w), 64'd0);
      chk("rst_done", done(w), 64'd0);
      chk("rst_result", res(w), 64'd0);
    end

    // Start already high when reset releases: accepted at the first edge.
    @(negedge clk);
    drv(8, 1'b1, 0, 0, 1'b0);
    rst = 1'b0;
    do_op(8, 32'h00, 32'h00, 1'b0, -1);
    @(posedge clk); #1;
    chk("done_one_cycle", done(8), 64'd0);

    // Back-to-back: second start driven during the done cycle.
    @(negedge clk);
    do_op(8, 32'hFF, 32'h01, 1'b0, -1);
    do_op(8, 32'h3C, 32'h0F, 1'b0, -1);
    @(posedge clk); #1;
    chk("done_one_cycle_b2b", done(8), 64'd0);

    // Start while busy is ignored.
    do_op(8, 32'hA5, 32'h5A, 1'b1, 3);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    drv(8, 1'b1, 32'h80, 32'h80, 1'b1);
    @(posedge clk); #1;
    drv(8, 1'b0, 0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_result", res(8), 64'd0);
    chk("midrst_busy", busy(8), 64'd0);
    chk("midrst_done", done(8), 64'd0);
    repeat (2) @(posedge clk);
    #1 chk("midrst_no_done", done(8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) prev[i] = 64'd0;
    do_op(8, 32'h80, 32'h80, 1'b1, -1);

    // Random 8-bit operands, mixing back-to-back and idle gaps.
    for (int i = 0; i < 30; i++) begin
      do_op(8, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom), -1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        chk("rand_done_clear", done(8), 64'd0);
      end
    end

    // WIDTH=4 exhaustive, back-to-back.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          do_op(4, 32'(a), 32'(b), 1'(c), -1);
    @(posedge clk); #1;
    chk("w4_done_clear", done(4), 64'd0);

    // WIDTH=1 full-adder truth table.
    for (int v = 0; v < 8; v++)
      do_op(1, 32'(v & 1), 32'((v >> 1) & 1), 1'((v >> 2) & 1), -1);
    @(posedge clk); #1;
    chk("w1_done_clear", done(1), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
